// File: rtl/xdma_w_beat_gen.sv
// Transmit side of the XDMA AXI W channel: forwards exactly trans_len_i source beats
// through a one-entry registered W stage and pulses trans_complete_o when done.
module xdma_w_beat_gen #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LenWidth  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [LenWidth-1:0]    trans_len_i,
  output logic                   busy_o,
  input  logic [DataWidth-1:0]   data_i,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  output logic [DataWidth-1:0]   axi_w_data_o,
  output logic [DataWidth/8-1:0] axi_w_strb_o,
  output logic                   axi_w_last_o,
  output logic                   axi_w_valid_o,
  input  logic                   axi_w_ready_i,
  output logic                   trans_complete_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned CntWidth  = LenWidth + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LenWidth-1:0] len_q;
  logic [CntWidth-1:0] len_ext;
  logic [CntWidth-1:0] acc_cnt_q;
  logic [CntWidth-1:0] sent_cnt_q;
  logic                src_hs;
  logic                w_hs;
  logic                start_ok;

  assign len_ext  = CntWidth'(len_q);
  assign start_ok = (state_q == IDLE) && start_i;
  assign src_hs   = data_valid_i && data_ready_o;
  assign w_hs     = axi_w_valid_o && axi_w_ready_i;

  // Accept a source beat only while beats remain and the W register is free or draining.
  assign data_ready_o     = (state_q == SEND) && (acc_cnt_q < len_ext) &&
                            (!axi_w_valid_o || axi_w_ready_i);
  assign busy_o           = (state_q != IDLE);
  assign trans_complete_o = (state_q == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Zero-length transfers pass through SEND for one cycle via the sent_cnt compare.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = SEND;
      SEND: if ((w_hs && axi_w_last_o) || (sent_cnt_q == len_ext)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q      <= '0;
      acc_cnt_q  <= '0;
      sent_cnt_q <= '0;
    end else if (start_ok) begin
      len_q      <= trans_len_i;
      acc_cnt_q  <= '0;
      sent_cnt_q <= '0;
    end else begin
      if (src_hs && (acc_cnt_q < len_ext)) acc_cnt_q <= acc_cnt_q + CntWidth'(1);
      if (w_hs && (sent_cnt_q < len_ext)) sent_cnt_q <= sent_cnt_q + CntWidth'(1);
    end
  end

  // One-entry W register: a load wins over a plain drain, so full throughput is kept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      axi_w_data_o  <= '0;
      axi_w_strb_o  <= '0;
      axi_w_last_o  <= 1'b0;
      axi_w_valid_o <= 1'b0;
    end else if (src_hs) begin
      axi_w_data_o  <= data_i;
      axi_w_strb_o  <= {StrbWidth{1'b1}};
      axi_w_last_o  <= ((acc_cnt_q + CntWidth'(1)) == len_ext);
      axi_w_valid_o <= 1'b1;
    end else if (w_hs) begin
      axi_w_strb_o  <= '0;
      axi_w_last_o  <= 1'b0;
      axi_w_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xdma_w_beat_gen.sv
// Directed bench for xdma_w_beat_gen: drives a source stream and an AXI W sink,
// checks beat order, last placement, stall stability and completion timing.
module tb_xdma_w_beat_gen;

  localparam int unsigned DataWidth = 64;
  localparam int unsigned LenWidth  = 16;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   start_i;
  logic [LenWidth-1:0]    trans_len_i;
  logic                   busy_o;
  logic [DataWidth-1:0]   data_i;
  logic                   data_valid_i;
  logic                   data_ready_o;
  logic [DataWidth-1:0]   axi_w_data_o;
  logic [DataWidth/8-1:0] axi_w_strb_o;
  logic                   axi_w_last_o;
  logic                   axi_w_valid_o;
  logic                   axi_w_ready_i;
  logic                   trans_complete_o;

  xdma_w_beat_gen #(.DataWidth(DataWidth), .LenWidth(LenWidth)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .trans_len_i      (trans_len_i),
    .busy_o           (busy_o),
    .data_i           (data_i),
    .data_valid_i     (data_valid_i),
    .data_ready_o     (data_ready_o),
    .axi_w_data_o     (axi_w_data_o),
    .axi_w_strb_o     (axi_w_strb_o),
    .axi_w_last_o     (axi_w_last_o),
    .axi_w_valid_o    (axi_w_valid_o),
    .axi_w_ready_i    (axi_w_ready_i),
    .trans_complete_o (trans_complete_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Per-transfer observations filled by run_xfer.
  int nbeats, last_cnt, last_idx, order_err, stab_err, strb_err;
  int ready_seen, cmpl_cnt, cmpl_cyc, gap_err, busy_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_ready"}, 64'(data_ready_o), 64'd0);
    check({tag, "_wvalid"}, 64'(axi_w_valid_o), 64'd0);
    check({tag, "_wlast"}, 64'(axi_w_last_o), 64'd0);
    check({tag, "_wstrb"}, 64'(axi_w_strb_o), 64'd0);
    check({tag, "_wdata"}, axi_w_data_o, 64'd0);
    check({tag, "_cmpl"}, 64'(trans_complete_o), 64'd0);
  endtask

  // src_mode 0: source always valid, 1: bubbles. rdy_mode 0: sink always ready, 1: random gaps.
  task automatic run_xfer(input int len, input logic [63:0] base, input int src_mode,
                          input int rdy_mode, input int abort_at, input int tail,
                          input int mid_start);
    int src_idx, gap, cyc, done_at, limit;
    logic stall, pl;
    logic [63:0] pd;
    @(posedge clk_i); #1;
    start_i     = 1'b1;
    trans_len_i = LenWidth'(len);
    @(posedge clk_i); #1;
    start_i     = 1'b0;
    trans_len_i = '0;
    nbeats = 0; last_cnt = 0; last_idx = -1; order_err = 0; stab_err = 0; strb_err = 0;
    ready_seen = 0; cmpl_cnt = 0; cmpl_cyc = -1; gap_err = 0; busy_err = 0;
    src_idx = 0; gap = 0; cyc = 0; done_at = -1; stall = 1'b0; pd = '0; pl = 1'b0;
    limit = len * 8 + 50;
    forever begin
      data_valid_i  = (src_idx < len) && ((src_mode == 0) || ((cyc % 3) != 1));
      data_i        = base + 64'(src_idx);
      axi_w_ready_i = (rdy_mode == 0) || (gap == 0);
      start_i       = (mid_start != 0) && (cyc == 4);
      trans_len_i   = (mid_start != 0) ? LenWidth'(2) : '0;
      @(negedge clk_i);
      if (data_valid_i && data_ready_o) src_idx++;
      if (data_ready_o) ready_seen++;
      if (stall && !(axi_w_valid_o && axi_w_data_o == pd && axi_w_last_o == pl)) stab_err++;
      if (axi_w_valid_o && axi_w_strb_o != '1) strb_err++;
      if (done_at < 0 && !busy_o) busy_err++;
      if (axi_w_valid_o && axi_w_ready_i) begin
        if (axi_w_data_o != base + 64'(nbeats)) order_err++;
        if (axi_w_last_o) begin
          last_cnt++;
          last_idx = nbeats;
        end
        if (cyc != nbeats + 1) gap_err++;
        nbeats++;
        if (rdy_mode != 0) gap = $urandom_range(0, 5);
      end else if (gap > 0) begin
        gap--;
      end
      stall = axi_w_valid_o && !axi_w_ready_i;
      pd    = axi_w_data_o;
      pl    = axi_w_last_o;
      if (trans_complete_o) begin
        cmpl_cnt++;
        if (done_at < 0) begin
          done_at  = cyc;
          cmpl_cyc = cyc;
        end
      end
      if (done_at >= 0 && cyc >= done_at + tail) break;
      if (abort_at > 0 && nbeats == abort_at) break;
      if (cyc > limit) begin
        check("timeout", 64'(cyc), 64'(limit));
        break;
      end
      cyc++;
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; trans_len_i = '0; data_i = '0;
    data_valid_i = 1'b0; axi_w_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_idle_outputs("reset");
    rst_i = 1'b0;

    // len=4, full throughput
    run_xfer(4, 64'hD000, 0, 0, 0, 3, 0);
    check("full_beats", 64'(nbeats), 64'd4);
    check("full_order", 64'(order_err), 64'd0);
    check("full_last_cnt", 64'(last_cnt), 64'd1);
    check("full_last_idx", 64'(last_idx), 64'd3);
    check("full_hs_timing", 64'(gap_err), 64'd0);
    check("full_cmpl_cyc", 64'(cmpl_cyc), 64'd5);
    check("full_cmpl_cnt", 64'(cmpl_cnt), 64'd1);
    check("full_strb", 64'(strb_err), 64'd0);
    check("full_busy", 64'(busy_err), 64'd0);
    check("full_idle_after", 64'(busy_o), 64'd0);

    // len=4, random sink stalls
    run_xfer(4, 64'hA100, 0, 1, 0, 3, 0);
    check("stall_beats", 64'(nbeats), 64'd4);
    check("stall_order", 64'(order_err), 64'd0);
    check("stall_stable", 64'(stab_err), 64'd0);
    check("stall_last_idx", 64'(last_idx), 64'd3);
    check("stall_cmpl_cnt", 64'(cmpl_cnt), 64'd1);

    // len=0, sink ready while nothing valid
    run_xfer(0, 64'h0, 0, 0, 0, 3, 0);
    check("zero_beats", 64'(nbeats), 64'd0);
    check("zero_ready_seen", 64'(ready_seen), 64'd0);
    check("zero_cmpl_cyc", 64'(cmpl_cyc), 64'd1);
    check("zero_cmpl_cnt", 64'(cmpl_cnt), 64'd1);

    // len=6 with source bubbles, sink stalls and an ignored mid-transfer start
    run_xfer(6, 64'hB600, 1, 1, 0, 4, 1);
    check("bubble_beats", 64'(nbeats), 64'd6);
    check("bubble_order", 64'(order_err), 64'd0);
    check("bubble_stable", 64'(stab_err), 64'd0);
    check("bubble_last_idx", 64'(last_idx), 64'd5);
    check("bubble_cmpl_cnt", 64'(cmpl_cnt), 64'd1);
    check("bubble_idle_after", 64'(busy_o), 64'd0);

    // Back-to-back len=1 then len=3
    run_xfer(1, 64'hC100, 0, 0, 0, 0, 0);
    check("b2b1_beats", 64'(nbeats), 64'd1);
    check("b2b1_last_idx", 64'(last_idx), 64'd0);
    check("b2b1_cmpl_cyc", 64'(cmpl_cyc), 64'd2);
    run_xfer(3, 64'hC300, 0, 0, 0, 2, 0);
    check("b2b2_beats", 64'(nbeats), 64'd3);
    check("b2b2_order", 64'(order_err), 64'd0);
    check("b2b2_last_idx", 64'(last_idx), 64'd2);
    check("b2b2_cmpl_cyc", 64'(cmpl_cyc), 64'd4);
    check("b2b2_cmpl_cnt", 64'(cmpl_cnt), 64'd1);

    // Reset mid-transfer after 3 of 8 beats
    run_xfer(8, 64'hE800, 0, 0, 3, 0, 0);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    check_idle_outputs("midrst");
    cmpl_cnt = 0;
    repeat (2) begin
      @(negedge clk_i);
      if (trans_complete_o) cmpl_cnt++;
    end
    check("midrst_no_cmpl", 64'(cmpl_cnt), 64'd0);
    rst_i = 1'b0;
    run_xfer(2, 64'hF200, 0, 0, 0, 2, 0);
    check("postrst_beats", 64'(nbeats), 64'd2);
    check("postrst_order", 64'(order_err), 64'd0);
    check("postrst_cmpl_cyc", 64'(cmpl_cyc), 64'd3);

    // Maximum length
    run_xfer(65535, 64'h1000_0000, 0, 0, 0, 2, 0);
    check("max_beats", 64'(nbeats), 64'd65535);
    check("max_order", 64'(order_err), 64'd0);
    check("max_last_cnt", 64'(last_cnt), 64'd1);
    check("max_last_idx", 64'(last_idx), 64'd65534);
    check("max_cmpl_cyc", 64'(cmpl_cyc), 64'd65536);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
